// File: rtl/fifo_drain_ctrl.sv
// FIFO consumer: reads words with one-cycle latency into a 2-entry skid
// buffer and re-emits them as a valid/ready stream in fixed-length bursts.
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH    = 16,
    parameter int BURST_LEN     = 4,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  err_underflow
);

    localparam int RCW = $clog2(BURST_LEN);
    localparam int WCW = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [RCW-1:0] RD_LAST  = RCW'(BURST_LEN - 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(FLUSH_TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [RCW-1:0]        rd_cnt_q, rd_cnt_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [FIFO_WIDTH-1:0] b0_data_q, b0_data_d;
    logic                  b0_last_q, b0_last_d;
    logic [FIFO_WIDTH-1:0] b1_data_q, b1_data_d;
    logic                  b1_last_q, b1_last_d;
    logic                  err_q, err_d;

    logic       pop;
    logic       push;
    logic       read_allowed;
    logic       rd_en;
    logic       rd_last;
    logic [2:0] credit;

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = b0_data_q;
    assign m_last        = m_valid && b0_last_q;
    assign fifo_rd_en    = rd_en;
    assign err_underflow = err_q;

    // Reads are only issued when the word will have a skid slot on arrival.
    always_comb begin
        pop          = m_valid && m_ready;
        push         = inflight_q;
        credit       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        read_allowed = (state_q == S_BURST) || (state_q == S_FLUSH);
        rd_en        = !rst && read_allowed && !fifo_empty && (credit < 3'd2);
        rd_last      = (state_q == S_FLUSH) || (rd_cnt_q == RD_LAST);

        inflight_d      = rd_en;
        inflight_last_d = rd_en && rd_last;
        err_d           = err_q || fifo_underflow;

        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !fifo_almostempty) begin
                    state_d    = S_BURST;
                    rd_cnt_d   = '0;
                    wait_cnt_d = '0;
                end else if (!fifo_empty) begin
                    if (wait_cnt_q == WAIT_MAX) begin
                        state_d    = S_FLUSH;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (rd_en) begin
                    if (rd_cnt_q == RD_LAST) begin
                        state_d  = S_IDLE;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RCW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (rd_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        occ_d     = occ_q;
        b0_data_d = b0_data_q;
        b0_last_d = b0_last_q;
        b1_data_d = b1_data_q;
        b1_last_d = b1_last_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    b0_data_d = fifo_data_out;
                    b0_last_d = inflight_last_q;
                end else begin
                    b1_data_d = fifo_data_out;
                    b1_last_d = inflight_last_q;
                end
            end
            2'b01: begin
                occ_d     = occ_q - 2'd1;
                b0_data_d = b1_data_q;
                b0_last_d = b1_last_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    b0_data_d = fifo_data_out;
                    b0_last_d = inflight_last_q;
                end else begin
                    b0_data_d = b1_data_q;
                    b0_last_d = b1_last_q;
                    b1_data_d = fifo_data_out;
                    b1_last_d = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rd_cnt_q        <= '0;
            wait_cnt_q      <= '0;
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            b0_data_q       <= '0;
            b0_last_q       <= 1'b0;
            b1_data_q       <= '0;
            b1_last_q       <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            occ_q           <= occ_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            b0_data_q       <= b0_data_d;
            b0_last_q       <= b0_last_d;
            b1_data_q       <= b1_data_d;
            b1_last_q       <= b1_last_d;
            err_q           <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO model feeding the DUT and a
// scoreboard of expected words/last flags checked at the output handshake.
module tb_fifo_drain_ctrl;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_empty;
    logic         fifo_almostempty;
    logic         uf_force;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         err_underflow;

    logic [W-1:0] fifo_q[$];
    exp_t         exp_q[$];
    int           rd_cyc[$];
    int           pop_cyc[$];
    int           wr_cnt = 0;
    int           rdn_cnt = 0;
    int           fifo_level;
    int           cyc = 0;
    int           rd_total = 0;
    int           rd_empty = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    bit           mon_en = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    exp_t         e;

    always #5 clk = ~clk;

    assign fifo_level       = wr_cnt - rdn_cnt;
    assign fifo_empty       = (fifo_level == 0);
    assign fifo_almostempty = (fifo_level == 1);

    fifo_drain_ctrl #(
        .FIFO_WIDTH(W),
        .BURST_LEN(4),
        .FLUSH_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty),
        .fifo_almostempty(fifo_almostempty),
        .fifo_underflow(uf_force),
        .fifo_rd_en(fifo_rd_en),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .err_underflow(err_underflow)
    );

    // FIFO model: one-cycle read latency
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd_en) begin
            if (fifo_level == 0) begin
                rd_empty = rd_empty + 1;
            end else begin
                fifo_data_out <= fifo_q.pop_front();
                rdn_cnt <= rdn_cnt + 1;
                rd_total = rd_total + 1;
                rd_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) begin
                n_checks++;
                if (m_valid === 1'b1 && m_data === prev_data && m_last === prev_last)
                    n_pass++;
                else
                    $display("FAIL hold: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             m_valid, m_data, m_last, prev_data, prev_last);
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra: got d=%h l=%b exp no word", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data === e.data && m_last === e.last)
                        n_pass++;
                    else
                        $display("FAIL sb_word: got d=%h l=%b exp d=%h l=%b",
                                 m_data, m_last, e.data, e.last);
                end
                pop_cyc.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [W-1:0] d, input logic last);
        fifo_q.push_back(d);
        wr_cnt = wr_cnt + 1;
        exp_q.push_back({d, last});
    endtask

    task automatic fifo_clear();
        fifo_q.delete();
        wr_cnt = rdn_cnt;
    endtask

    task automatic drain(input int maxc, output bit ok);
        int i;
        i = 0;
        while (i < maxc && !(exp_q.size() == 0 && fifo_level == 0 && !m_valid)) begin
            tick();
            i++;
        end
        ok = (exp_q.size() == 0 && fifo_level == 0 && !m_valid);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        uf_force = 1'b0;
        tick();
        n_checks++;
        if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en_during: got %b exp 0", fifo_rd_en);
        else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0)
            $display("FAIL rst_out: got v=%b l=%b d=%h exp 0 0 0000", m_valid, m_last, m_data);
        else n_pass++;
        n_checks++;
        if (fifo_rd_en !== 1'b0 || err_underflow !== 1'b0)
            $display("FAIL rst_ctrl: got rd=%b err=%b exp 0 0", fifo_rd_en, err_underflow);
        else n_pass++;
    endtask

    task automatic test_stream();
        int  base;
        bit  ok;
        mon_en  = 1;
        m_ready = 1'b1;
        base    = rd_total;
        rd_cyc.delete();
        pop_cyc.delete();
        for (int i = 1; i <= 8; i++) fifo_write(W'(i), (i % 4) == 0);
        drain(100, ok);
        n_checks++;
        if (!ok) $display("FAIL stream_drain: got left=%0d exp 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (rd_total - base != 8) $display("FAIL stream_reads: got %0d exp 8", rd_total - base);
        else n_pass++;
        n_checks++;
        if (rd_cyc.size() != 8 || pop_cyc.size() != 8) begin
            $display("FAIL stream_count: got rd=%0d pop=%0d exp 8 8", rd_cyc.size(), pop_cyc.size());
        end else begin
            n_pass++;
            for (int g = 0; g < 2; g++) begin
                for (int k = 1; k < 4; k++) begin
                    n_checks++;
                    if (rd_cyc[4*g+k] != rd_cyc[4*g] + k || pop_cyc[4*g+k] != pop_cyc[4*g] + k)
                        $display("FAIL stream_b2b: got rd=%0d pop=%0d exp rd=%0d pop=%0d",
                                 rd_cyc[4*g+k], pop_cyc[4*g+k], rd_cyc[4*g] + k, pop_cyc[4*g] + k);
                    else n_pass++;
                end
            end
            n_checks++;
            if (pop_cyc[0] != rd_cyc[0] + 1)
                $display("FAIL stream_latency: got %0d exp %0d", pop_cyc[0], rd_cyc[0] + 1);
            else n_pass++;
            n_checks++;
            if (rd_cyc[4] > rd_cyc[3] + 2)
                $display("FAIL stream_gap: got %0d exp <=%0d", rd_cyc[4], rd_cyc[3] + 2);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        m_ready = 1'b0;
        base    = rd_total;
        for (int i = 1; i <= 8; i++) fifo_write(W'(i), (i % 4) == 0);
        repeat (10) tick();
        n_checks++;
        if (rd_total - base != 2) $display("FAIL bp_reads: got %0d exp 2", rd_total - base);
        else n_pass++;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0001)
            $display("FAIL bp_head: got v=%b d=%h exp v=1 d=0001", m_valid, m_data);
        else n_pass++;
        m_ready = 1'b1;
        drain(100, ok);
        n_checks++;
        if (!ok || rd_total - base != 8)
            $display("FAIL bp_drain: got left=%0d reads=%0d exp 0 8", exp_q.size(), rd_total - base);
        else n_pass++;
    endtask

    task automatic test_flush();
        int base;
        bit ok;
        m_ready = 1'b1;
        base    = rd_total;
        fifo_write(16'hABCD, 1'b1);
        repeat (8) tick();
        n_checks++;
        if (rd_total - base != 0) $display("FAIL flush_early: got %0d exp 0", rd_total - base);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_total - base != 1) $display("FAIL flush_read: got %0d exp 1", rd_total - base);
        else n_pass++;
        drain(20, ok);
        n_checks++;
        if (!ok) $display("FAIL flush_drain: got left=%0d exp 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_gap();
        int base;
        bit ok;
        m_ready = 1'b1;
        base    = rd_total;
        fifo_write(16'h0011, 1'b0);
        fifo_write(16'h0022, 1'b0);
        repeat (20) tick();
        n_checks++;
        if (rd_total - base != 2 || rd_empty != 0)
            $display("FAIL gap_stall: got reads=%0d empty_rd=%0d exp 2 0", rd_total - base, rd_empty);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || m_valid !== 1'b0)
            $display("FAIL gap_partial: got left=%0d v=%b exp 0 0", exp_q.size(), m_valid);
        else n_pass++;
        fifo_write(16'h0033, 1'b0);
        fifo_write(16'h0044, 1'b1);
        drain(30, ok);
        n_checks++;
        if (!ok || rd_total - base != 4)
            $display("FAIL gap_resume: got left=%0d reads=%0d exp 0 4", exp_q.size(), rd_total - base);
        else n_pass++;
    endtask

    task automatic test_underflow();
        uf_force = 1'b1;
        tick();
        uf_force = 1'b0;
        n_checks++;
        if (err_underflow !== 1'b1) $display("FAIL uf_set: got %b exp 1", err_underflow);
        else n_pass++;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_write(W'(16'h0200 + i), (i % 4) == 0);
        for (int c = 0; c < 50; c++) begin
            tick();
            n_checks++;
            if (err_underflow !== 1'b1) $display("FAIL uf_hold: got %b exp 1 cyc %0d", err_underflow, c);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL uf_traffic: got left=%0d exp 0", exp_q.size());
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (err_underflow !== 1'b0) $display("FAIL uf_clear: got %b exp 0", err_underflow);
        else n_pass++;
    endtask

    task automatic test_reset_midburst();
        int base;
        int n;
        int vcnt;
        m_ready = 1'b0;
        base    = rd_total;
        for (int i = 1; i <= 4; i++) fifo_write(W'(16'h0100 + i), i == 4);
        n = 0;
        while (n < 20 && rd_total - base < 2) begin
            tick();
            n++;
        end
        n_checks++;
        if (rd_total - base != 2) $display("FAIL mid_setup: got %0d exp 2", rd_total - base);
        else n_pass++;
        mon_en  = 0;
        m_ready = 1'b1;
        rst     = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd_en !== 1'b0) $display("FAIL mid_rd_gate: got %b exp 0", fifo_rd_en);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0 || err_underflow !== 1'b0)
            $display("FAIL mid_after: got v=%b l=%b rd=%b err=%b exp 0 0 0 0",
                     m_valid, m_last, fifo_rd_en, err_underflow);
        else n_pass++;
        n_checks++;
        if (rd_total - base != 2) $display("FAIL mid_no_read: got %0d exp 2", rd_total - base);
        else n_pass++;
        fifo_clear();
        exp_q.delete();
        mon_en = 1;
        vcnt   = 0;
        repeat (6) begin
            tick();
            if (m_valid) vcnt++;
        end
        n_checks++;
        if (vcnt != 0) $display("FAIL mid_discard: got %0d valid cycles exp 0", vcnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_gap();
        test_underflow();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
